ball_pixel_renderer: RTL and testbench
======================================

// Module: ball_pixel_renderer
// PURPOSE
//  Downstream of the ball-position stage. Takes the ball's top-left position (hor_pos/ver_pos)
//  and the VGA scan coordinates, and produces the 12-bit pixel colour of a filled round ball
//  on a flat background. Position is sampled once per frame to prevent tearing. A 3-stage
//  pipeline delays the syncs and the valid flag so they stay aligned with the colour output.
// PARAMETERS
//  SIZE        25      ball bounding-box edge length in pixels (diameter)
//  BALL_COLOR  12'hF80 RGB444 colour of ball pixels
//  BG_COLOR    12'h026 RGB444 colour of non-ball active-video pixels
//  SYNC_IDLE   1'b1    inactive level of hsync/vsync (used for reset value)
// PORTS
//  clock        in   1   pixel clock
//  reset        in   1   asynchronous, active-low reset
//  hor_pos      in   12  ball left edge x, from the position stage
//  ver_pos      in   11  ball top edge y, from the position stage
//  pix_x        in   12  current scan x
//  pix_y        in   11  current scan y
//  pix_valid    in   1   1 = active video for pix_x/pix_y
//  frame_start  in   1   1-cycle pulse, first cycle of vertical blank
//  hsync_in     in   1   raw hsync from the timing generator
//  vsync_in     in   1   raw vsync from the timing generator
//  rgb          out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
//  hsync_out    out  1   hsync_in delayed 3 cycles
//  vsync_out    out  1   vsync_in delayed 3 cycles
//  valid_out    out  1   pix_valid delayed 3 cycles
//  hit          out  1   1 = rgb is a ball pixel
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - rgb=0, hit=0, valid_out=0, hsync_out=vsync_out=SYNC_IDLE.
//   - Shadow position bx=0, by=0. All pipeline stages cleared.
//  Shadow position:
//   - bx<=hor_pos and by<=ver_pos only on a clock edge where frame_start=1.
//   - A pixel presented in the same cycle as frame_start uses the OLD bx/by.
//   - hor_pos/ver_pos changes between frame_start pulses have no visible effect.
//  S1:
//   - dx = {1'b0,pix_x} - {1'b0,bx} (13-bit signed); dy computed the same way (12-bit).
//   - inbox = pix_valid & 0<=dx<SIZE & 0<=dy<SIZE.
//   - No wrap-around: bx+SIZE beyond 4095 clips and does not reappear at x=0.
//  S2:
//   - u = 2*dx-(SIZE-1), v = 2*dy-(SIZE-1) (signed).
//   - sq = u*u + v*v, unsigned, width >= 2*clog2(2*SIZE)+1.
//  S3:
//   - hit = inbox & (sq <= SIZE*SIZE).
//   - rgb = !valid ? 0 : hit ? BALL_COLOR : BG_COLOR.
//  Latency:
//   - Exactly 3 clocks from pix_*/h/vsync_in to rgb/hit/valid_out/h/vsync_out.
//   - Fully pipelined, one pixel per clock, no stalls.
//  Blanking: pix_valid=0 forces rgb=0 and hit=0 regardless of position.
// STRUCTURE
//  - Package ball_pkg holds:
//     - constants SIZE, HOR_FIELD=799, VER_FIELD=599;
//     - colour constants BALL_COLOR, BG_COLOR;
//     - typedef rgb444_t (12 bits).
//  - Sub-module pipe_delay #(WIDTH,DEPTH) is the reset-clearable shift register used for
//    {hsync,vsync,valid}, with a per-bit reset value.
//  - All arithmetic is inline in this module. No clock-domain crossing.
// TESTING
//  1 Reset: drive reset=0 mid-line with valid pixels -> the same cycle, rgb=0, hit=0,
//    valid_out=0 and syncs=1; after release, rgb stays 0 for 3 clocks.
//  2 Centre: hor_pos=100, ver_pos=50, pulse frame_start, then pixel (112,62) valid ->
//    3 clocks later rgb=12'hF80, hit=1.
//  3 Circle edge, same position:
//     - (100,50) -> rgb=12'h026, hit=0 (corner, sq=1152).
//     - (100,62) -> rgb=12'hF80 (sq=576).
//     - (125,62) -> 12'h026 (outside box).
//  4 Tear-free update:
//     - Set hor_pos=300 with no frame_start -> (112,62) is still ball and (312,62) is BG.
//     - After frame_start the result is reversed.
//     - With frame_start and the pixel in the same cycle, the old position is used.
//  5 Blanking/sync alignment: pix_valid=0 at (112,62) -> rgb=0, hit=0. A toggling
//    hsync_in/vsync_in pattern appears on hsync_out/vsync_out exactly 3 clocks later.
//  6 Clip: hor_pos=4090, frame_start, scan x=4090..4095 and x=0..20 on row ver_pos+12 ->
//    ball only at x>=4090; x=0..20 is BG (no wrap).

Source files
------------

// File: rtl/ball_pkg.sv
// Shared constants and types for the ball renderer: ball geometry, playfield extent
// and RGB444 colours.
package ball_pkg;

    typedef logic [11:0] rgb444_t;

    localparam int SIZE      = 25;
    localparam int HOR_FIELD = 799;
    localparam int VER_FIELD = 599;
    localparam int OFS_W     = $clog2(2 * SIZE);

    localparam rgb444_t BALL_COLOR = 12'hF80;
    localparam rgb444_t BG_COLOR   = 12'h026;
    localparam logic    SYNC_IDLE  = 1'b1;

    // |2*d - (SIZE-1)|: doubled distance of a box column/row from the ball centre
    function automatic logic [OFS_W-1:0] centre_offset(input logic [OFS_W-1:0] twice_d);
        logic [OFS_W-1:0] diam_m1;
        diam_m1 = OFS_W'(SIZE - 1);
        if (twice_d >= diam_m1) begin
            return twice_d - diam_m1;
        end else begin
            return diam_m1 - twice_d;
        end
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Reset-clearable shift register: d_i appears on q_o DEPTH clocks later; every stage
// resets to RST_VAL so idle-high signals come out of reset at their idle level.
module pipe_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Delay line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ball_pixel_renderer.sv
// Renders a filled round ball on a flat background. Ball position is latched once per
// frame; a 3-stage pipeline (box test, squared radius, colour) keeps syncs aligned.
module ball_pixel_renderer
    import ball_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] hor_pos,
    input  logic [10:0] ver_pos,
    input  logic [11:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic        pix_valid,
    input  logic        frame_start,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        valid_out,
    output logic        hit
);

    localparam int              DW     = $clog2(SIZE);
    localparam int              SQ_W   = 2 * OFS_W + 1;
    localparam logic [12:0]     SIZE_X = 13'(SIZE);
    localparam logic [11:0]     SIZE_Y = 12'(SIZE);
    localparam logic [SQ_W-1:0] R_SQ   = SQ_W'(SIZE * SIZE);

    logic [11:0]       bx_q, bx_d;
    logic [10:0]       by_q, by_d;
    logic              inbox1_q, inbox1_d, valid1_q;
    logic [DW-1:0]     dx1_q, dx1_d, dy1_q, dy1_d;
    logic              inbox2_q, inbox2_d, valid2_q;
    logic [SQ_W-1:0]   sq2_q, sq2_d;
    rgb444_t           rgb_q, rgb_d;
    logic              hit_q, hit_d;
    logic [12:0]       dx_s;
    logic [11:0]       dy_s;
    logic [OFS_W-1:0]  au_s, av_s;
    logic [2*OFS_W-1:0] uu_s, vv_s;
    logic [2:0]        sync_q_s;

    // Next-state for shadow position and all three datapath stages
    always_comb begin
        bx_d     = bx_q;
        by_d     = by_q;
        if (frame_start) begin
            bx_d = hor_pos;
            by_d = ver_pos;
        end else begin
            bx_d = bx_q;
            by_d = by_q;
        end

        // Zero-extended subtraction: a negative offset can never alias into the box
        dx_s     = {1'b0, pix_x} - {1'b0, bx_q};
        dy_s     = {1'b0, pix_y} - {1'b0, by_q};
        inbox1_d = pix_valid && !dx_s[12] && (dx_s < SIZE_X)
                             && !dy_s[11] && (dy_s < SIZE_Y);
        dx1_d    = dx_s[DW-1:0];
        dy1_d    = dy_s[DW-1:0];

        au_s     = centre_offset(OFS_W'({dx1_q, 1'b0}));
        av_s     = centre_offset(OFS_W'({dy1_q, 1'b0}));
        uu_s     = {{OFS_W{1'b0}}, au_s} * {{OFS_W{1'b0}}, au_s};
        vv_s     = {{OFS_W{1'b0}}, av_s} * {{OFS_W{1'b0}}, av_s};
        sq2_d    = {1'b0, uu_s} + {1'b0, vv_s};
        inbox2_d = inbox1_q;

        hit_d    = inbox2_q && (sq2_q <= R_SQ);
        if (!valid2_q) begin
            rgb_d = 12'h000;
        end else if (hit_d) begin
            rgb_d = BALL_COLOR;
        end else begin
            rgb_d = BG_COLOR;
        end
    end

    // Pipeline and shadow-position registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bx_q     <= 12'd0;
            by_q     <= 11'd0;
            inbox1_q <= 1'b0;
            valid1_q <= 1'b0;
            dx1_q    <= '0;
            dy1_q    <= '0;
            inbox2_q <= 1'b0;
            valid2_q <= 1'b0;
            sq2_q    <= '0;
            rgb_q    <= 12'h000;
            hit_q    <= 1'b0;
        end else begin
            bx_q     <= bx_d;
            by_q     <= by_d;
            inbox1_q <= inbox1_d;
            valid1_q <= pix_valid;
            dx1_q    <= dx1_d;
            dy1_q    <= dy1_d;
            inbox2_q <= inbox2_d;
            valid2_q <= valid1_q;
            sq2_q    <= sq2_d;
            rgb_q    <= rgb_d;
            hit_q    <= hit_d;
        end
    end

    pipe_delay #(
        .WIDTH   (3),
        .DEPTH   (3),
        .RST_VAL ({SYNC_IDLE, SYNC_IDLE, 1'b0})
    ) u_sync_delay (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    ({hsync_in, vsync_in, pix_valid}),
        .q_o    (sync_q_s)
    );

    assign hsync_out = sync_q_s[2];
    assign vsync_out = sync_q_s[1];
    assign valid_out = sync_q_s[0];
    assign rgb       = rgb_q;
    assign hit       = hit_q;

endmodule

// File: tb/tb_ball_pixel_renderer.sv
// Self-checking bench for ball_pixel_renderer: directed scenarios plus random traffic,
// all compared against an arithmetic reference model of the ball and a 3-deep delay queue.
module tb_ball_pixel_renderer;

    logic        clock;
    logic        reset;
    logic [11:0] hor_pos;
    logic [10:0] ver_pos;
    logic [11:0] pix_x;
    logic [10:0] pix_y;
    logic        pix_valid;
    logic        frame_start;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        valid_out;
    logic        hit;
    logic [15:0] obs;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mbx = 0;
    int          mby = 0;
    logic [15:0] exp_q [$];

    localparam logic [15:0] RESET_OBS = 16'h0003;

    ball_pixel_renderer dut (
        .clock       (clock),
        .reset       (reset),
        .hor_pos     (hor_pos),
        .ver_pos     (ver_pos),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .valid_out   (valid_out),
        .hit         (hit)
    );

    assign obs = {rgb, hit, valid_out, hsync_out, vsync_out};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Ball = points of the 25x25 box whose doubled offset from centre lies within radius 25
    function automatic logic [15:0] model(input int px, input int py, input logic pv,
                                          input logic hs, input logic vs,
                                          input int bx, input int by);
        int dx, dy, u, v;
        logic h;
        logic [11:0] c;
        dx = px - bx;
        dy = py - by;
        u  = 2 * dx - 24;
        v  = 2 * dy - 24;
        h  = pv && dx >= 0 && dx < 25 && dy >= 0 && dy < 25 && (u * u + v * v <= 625);
        c  = !pv ? 12'h000 : (h ? 12'hF80 : 12'h026);
        return {c, h, pv, hs, vs};
    endfunction

    task automatic model_reset();
        mbx = 0;
        mby = 0;
        exp_q.delete();
        exp_q.push_back(RESET_OBS);
        exp_q.push_back(RESET_OBS);
    endtask

    // One clock: record expected output for current inputs, return the one now due
    task automatic step(output logic [15:0] e_o);
        exp_q.push_back(model(int'(pix_x), int'(pix_y), pix_valid, hsync_in, vsync_in, mbx, mby));
        @(posedge clock);
        if (frame_start) begin
            mbx = int'(hor_pos);
            mby = int'(ver_pos);
        end
        #1;
        e_o = exp_q.pop_front();
    endtask

    // Present one pixel, then let it drain to the outputs
    task automatic run_pixel(input logic [11:0] x, input logic [10:0] y, input logic v,
                             input logic fs, output logic [15:0] e_o);
        logic [15:0] dummy;
        pix_x       = x;
        pix_y       = y;
        pix_valid   = v;
        frame_start = fs;
        step(dummy);
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        step(dummy);
        step(e_o);
    endtask

    task automatic test_reset();
        logic [15:0] e;
        hor_pos = 12'd100;
        ver_pos = 11'd50;
        run_pixel(12'd0, 11'd0, 1'b0, 1'b1, e);
        pix_x = 12'd112; pix_y = 11'd62; pix_valid = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0;
        for (int i = 0; i < 3; i++) step(e);
        n_checks++;
        if (obs !== 16'hF80C) $display("FAIL pre_reset obs=%h expected=%h", obs, 16'hF80C);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== RESET_OBS) $display("FAIL async_reset obs=%h expected=%h", obs, RESET_OBS);
        else n_pass++;
        model_reset();
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(e);
            n_checks++;
            if (obs !== e) $display("FAIL post_reset cycle=%0d obs=%h expected=%h", i, obs, e);
            else n_pass++;
            if (i < 2) begin
                n_checks++;
                if (rgb !== 12'h000) $display("FAIL post_reset_rgb cycle=%0d rgb=%h expected=000", i, rgb);
                else n_pass++;
            end
        end
        hsync_in = 1'b1; vsync_in = 1'b1; pix_valid = 1'b0;
    endtask

    task automatic test_centre();
        logic [15:0] e;
        hor_pos = 12'd100;
        ver_pos = 11'd50;
        run_pixel(12'd0, 11'd0, 1'b0, 1'b1, e);
        run_pixel(12'd112, 11'd62, 1'b1, 1'b0, e);
        n_checks++;
        if ({rgb, hit} !== {12'hF80, 1'b1}) $display("FAIL centre rgb=%h hit=%b expected F80/1", rgb, hit);
        else n_pass++;
        n_checks++;
        if (obs !== e) $display("FAIL centre_model obs=%h expected=%h", obs, e);
        else n_pass++;
    endtask

    task automatic test_edge();
        logic [15:0] e;
        logic [11:0] xs [3] = '{12'd100, 12'd100, 12'd125};
        logic [10:0] ys [3] = '{11'd50, 11'd62, 11'd62};
        logic [12:0] want [3] = '{{12'h026, 1'b0}, {12'hF80, 1'b1}, {12'h026, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            run_pixel(xs[i], ys[i], 1'b1, 1'b0, e);
            n_checks++;
            if ({rgb, hit} !== want[i])
                $display("FAIL edge x=%0d y=%0d rgb/hit=%h expected=%h", xs[i], ys[i], {rgb, hit}, want[i]);
            else n_pass++;
            n_checks++;
            if (obs !== e) $display("FAIL edge_model i=%0d obs=%h expected=%h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_tear_free();
        logic [15:0] e;
        logic [11:0] xs   [7] = '{12'd112, 12'd312, 12'd0, 12'd112, 12'd312, 12'd312, 12'd312};
        logic        vs_t [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        fs   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [11:0] want [7] = '{12'hF80, 12'h026, 12'h000, 12'h026, 12'hF80, 12'hF80, 12'h026};
        hor_pos = 12'd300;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) hor_pos = 12'd100;
            run_pixel(xs[i], 11'd62, vs_t[i], fs[i], e);
            n_checks++;
            if (rgb !== want[i]) $display("FAIL tear step=%0d rgb=%h expected=%h", i, rgb, want[i]);
            else n_pass++;
            n_checks++;
            if (obs !== e) $display("FAIL tear_model step=%0d obs=%h expected=%h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_blank_sync();
        logic [15:0] e;
        logic [1:0]  hist [16];
        run_pixel(12'd112, 11'd62, 1'b0, 1'b0, e);
        n_checks++;
        if ({rgb, hit} !== 13'd0) $display("FAIL blank rgb=%h hit=%b expected 000/0", rgb, hit);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            hist[i]   = {i[0], i[1] ^ i[2]};
            hsync_in  = hist[i][1];
            vsync_in  = hist[i][0];
            pix_x     = 12'(100 + i);
            pix_y     = 11'd62;
            pix_valid = i[0];
            step(e);
            n_checks++;
            if (obs !== e) $display("FAIL sync_model cycle=%0d obs=%h expected=%h", i, obs, e);
            else n_pass++;
            if (i >= 2) begin
                n_checks++;
                if ({hsync_out, vsync_out} !== hist[i-2])
                    $display("FAIL sync_delay cycle=%0d syncs=%b expected=%b", i, {hsync_out, vsync_out}, hist[i-2]);
                else n_pass++;
            end
        end
        hsync_in = 1'b1; vsync_in = 1'b1; pix_valid = 1'b0;
    endtask

    task automatic test_clip();
        logic [15:0] e;
        logic [11:0] x;
        logic [11:0] want;
        hor_pos = 12'd4090;
        ver_pos = 11'd50;
        run_pixel(12'd0, 11'd0, 1'b0, 1'b1, e);
        for (int k = 0; k < 27; k++) begin
            x    = (k < 6) ? 12'(4090 + k) : 12'(k - 6);
            want = (k < 6) ? 12'hF80 : 12'h026;
            run_pixel(x, 11'd62, 1'b1, 1'b0, e);
            n_checks++;
            if (rgb !== want) $display("FAIL clip x=%0d rgb=%h expected=%h", x, rgb, want);
            else n_pass++;
            n_checks++;
            if (obs !== e) $display("FAIL clip_model x=%0d obs=%h expected=%h", x, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back_random();
        logic [15:0] e;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                hor_pos = 12'($urandom_range(0, 4095));
                ver_pos = 11'($urandom_range(0, 2047));
            end
            frame_start = ($urandom_range(0, 15) == 0);
            pix_x       = 12'(mbx + int'($urandom_range(0, 30)) - 3);
            pix_y       = 11'(mby + int'($urandom_range(0, 30)) - 3);
            pix_valid   = ($urandom_range(0, 4) != 0);
            hsync_in    = 1'($urandom_range(0, 1));
            vsync_in    = 1'($urandom_range(0, 1));
            step(e);
            n_checks++;
            if (obs !== e) $display("FAIL random cycle=%0d obs=%h expected=%h", i, obs, e);
            else n_pass++;
        end
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        hor_pos     = 12'd0;
        ver_pos     = 11'd0;
        pix_x       = 12'd0;
        pix_y       = 11'd0;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        #20;
        n_checks++;
        if (obs !== RESET_OBS) $display("FAIL reset_state obs=%h expected=%h", obs, RESET_OBS);
        else n_pass++;
        #6 reset = 1'b1;
        model_reset();
        test_reset();
        test_centre();
        test_edge();
        test_tear_free();
        test_blank_sync();
        test_clip();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
